// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//   Issue and sequencing stage that sits directly in front of the combinational
//   ALU (alu_a5). It takes one command at a time and registers its operands for
//   the ALU. One cycle later it captures the ALU result and the compare flags.
//   It then holds them under an output valid/ready handshake. The last result
//   is also kept in an accumulator, so a chained command can use it as operand
//   a. The block also counts completed, handed-off operations.
//
// Ports
//   clk, rst_n                        clock, async active-low reset
//   in_valid/in_ready                 command handshake
//   in_sel, in_a, in_b                opcode and operands
//   in_acc                            use accumulator instead of in_a
//   acc_clr                           synchronous accumulator clear
//   alu_sel, alu_a, alu_b             registered operands to alu_a5
//   alu_result, alu_agrtb/altb/aeqb   combinational results from alu_a5
//   out_valid/out_ready               result handshake
//   out_result, out_flags             captured result, {agrtb, altb, aeqb}
//   op_count                          completed operations (wraps)
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int               WIDTH    = 12,
  parameter int               SEL_W    = 4,
  parameter int               CNT_W    = 16,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic [SEL_W-1:0] alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_agrtb,
  input  logic             alu_altb,
  input  logic             alu_aeqb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_flags,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e             state_q,      state_d;
  logic [SEL_W-1:0]   alu_sel_q,    alu_sel_d;
  logic [WIDTH-1:0]   alu_a_q,      alu_a_d;
  logic [WIDTH-1:0]   alu_b_q,      alu_b_d;
  logic [WIDTH-1:0]   acc_q,        acc_d;
  logic [WIDTH-1:0]   out_result_q, out_result_d;
  logic [2:0]         out_flags_q,  out_flags_d;
  logic               out_valid_q,  out_valid_d;
  logic [CNT_W-1:0]   op_count_q,   op_count_d;
  logic [WIDTH-1:0]   acc_next;

  // Ready is decoded from the state. It therefore reads 1 during reset.
  assign in_ready = (state_q == IDLE);

  // Accumulator as seen this cycle: a clear in the same cycle takes effect
  // immediately, so a chained command issued with acc_clr sees ACC_INIT.
  assign acc_next = acc_clr ? ACC_INIT : acc_q;

  always_comb begin
    // NOTE: every signal gets a hold default first. A branch that does not
    // assign a signal then cannot infer a latch.
    state_d      = state_q;
    alu_sel_d    = alu_sel_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    acc_d        = acc_next;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    out_valid_d  = out_valid_q;
    op_count_d   = op_count_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          alu_sel_d = in_sel;
          alu_b_d   = in_b;
          alu_a_d   = in_acc ? acc_next : in_a;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        // The ALU has settled on the registered operands. Capture the result.
        // This overrides any acc_clr in the same cycle.
        out_result_d = alu_result;
        out_flags_d  = {alu_agrtb, alu_altb, alu_aeqb};
        acc_d        = alu_result;
        out_valid_d  = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only. All flops then
  // update together at the edge, whatever the order of the blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_sel_q    <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      acc_q        <= ACC_INIT;
      out_result_q <= '0;
      out_flags_q  <= '0;
      out_valid_q  <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      alu_sel_q    <= alu_sel_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      acc_q        <= acc_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
      out_valid_q  <= out_valid_d;
      op_count_q   <= op_count_d;
    end
  end

  assign alu_sel    = alu_sel_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign out_valid  = out_valid_q;
  assign op_count   = op_count_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequencing stage that sits directly upstream of alu_a5. It accepts ALU commands (sel, a, b) over a valid/ready handshake and registers the operands that drive alu_a5. It captures alu_a5's combinational result and compare flags into an output register held under a second valid/ready handshake. It also keeps an accumulator, so that chained operations can reuse the previous result as operand a, and counts completed operations.

Parameters:
WIDTH, 12, operand/result width (matches alu_a5 a/b/result)
SEL_W, 4, opcode width (matches alu_a5 sel)
CNT_W, 16, completed-operation counter width
ACC_INIT, 0, accumulator value after reset / acc_clr

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  command valid
in_ready  output  1  command ready
in_sel  input  SEL_W  opcode
in_a  input  WIDTH  operand a
in_b  input  WIDTH  operand b
in_acc  input  1  1 = use accumulator instead of in_a
acc_clr  input  1  synchronous accumulator clear
alu_sel  output  SEL_W  registered opcode to alu_a5 sel
alu_a  output  WIDTH  registered operand to alu_a5 a
alu_b  output  WIDTH  registered operand to alu_a5 b
alu_result  input  WIDTH  from alu_a5 result
alu_agrtb  input  1  from alu_a5 agrtb
alu_altb  input  1  from alu_a5 altb
alu_aeqb  input  1  from alu_a5 aeqb
out_valid  output  1  result valid
out_ready  input  1  consumer ready
out_result  output  WIDTH  captured result
out_flags  output  3  captured {agrtb, altb, aeqb}
op_count  output  CNT_W  number of completed (handed-off) operations

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE.
  - alu_sel, alu_a, alu_b, out_result, out_flags, op_count = 0.
  - Accumulator = ACC_INIT; out_valid = 0.
  - in_ready is decoded from state, so it reads 1 while in reset.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: in_ready = 1. On in_valid && in_ready at an edge:
    - alu_sel <= in_sel; alu_b <= in_b.
    - alu_a <= (in_acc ? acc_next : in_a), where acc_next = ACC_INIT if acc_clr is high that cycle, else the accumulator.
    - Go to EXEC.
  - EXEC: in_ready = 0; alu_a5 settles combinationally. At the next edge:
    - out_result <= alu_result; out_flags <= {alu_agrtb, alu_altb, alu_aeqb}.
    - Accumulator <= alu_result; out_valid <= 1; go to DONE.
  - DONE: in_ready = 0. out_result and out_flags are held stable while out_valid && !out_ready. On out_valid && out_ready at an edge:
    - out_valid <= 0; op_count <= op_count + 1; go to IDLE.
- Timing: a command accepted at edge N drives alu_* after N; the result is captured at N+1; out_valid is high after N+1. Minimum issue interval is 3 cycles.
- alu_sel, alu_a and alu_b hold their last values outside IDLE acceptance; they never change in EXEC or DONE.
- acc_clr is honoured in any state. If it coincides with the EXEC capture edge, the capture wins (accumulator <= alu_result).
- in_acc with no prior operation uses ACC_INIT.
- op_count wraps from 2^CNT_W-1 to 0 with no saturation.
- in_valid in EXEC/DONE is ignored; the command is not consumed. The upstream source must hold it per valid/ready rules.
- out_ready high with out_valid low has no effect.
- Widths: no extension or truncation; all operand/result paths are WIDTH bits.
- Reset asserted mid-operation aborts it: no out_valid pulse, op_count unchanged from 0, accumulator = ACC_INIT.

Test Plan (bench drives alu_result/flags from a stub model of alu_a5):
- Reset, then in_valid=1, sel=4'h3, a=12'h0FF, b=12'h001:
  - Expect in_ready=1 in IDLE.
  - Expect alu_a=12'h0FF, alu_b=12'h001, alu_sel=4'h3 one cycle after acceptance.
  - Stub returns result 12'h100, flags 3'b100; expect out_result=12'h100, out_flags=3'b100 and out_valid=1 two edges after acceptance.
- Hold out_ready=0 for 5 cycles in DONE, then 1:
  - Expect out_* stable and in_ready=0 throughout.
  - Expect out_valid to drop and op_count=1 after the handshake edge.
- Chained op: second command with in_acc=1, in_a=12'hABC, b=12'h002 after the op above → expect alu_a=12'h100 (accumulator), not 12'hABC.
- acc_clr=1 in the same cycle as an accepted in_acc=1 command → expect alu_a=ACC_INIT (12'h000).
- Preload op_count to 16'hFFFF via 65535 ops (or force) and complete one more → expect op_count=16'h0000.
- Assert rst_n=0 asynchronously in EXEC → expect out_valid=0, alu_a/alu_b/alu_sel=0 and in_ready=1 immediately, with no result pulse after release.
